// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back buffer: byte-lane word type and
// word-aligned address masking.
package wb_pkg;

  localparam int WORD_BYTES = 4;
  localparam int MAX_ADDR_W = 64;

  // Lane 0 is the least-significant byte of the packed word.
  typedef logic [WORD_BYTES-1:0][7:0] byte_lanes_t;
  typedef logic [MAX_ADDR_W-1:0]      wide_addr_t;

  function automatic wide_addr_t word_addr(input wide_addr_t addr);
    return addr & ~wide_addr_t'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/wb_match.sv
// Combinational priority match over buffer entries presented oldest-first;
// the highest-indexed (youngest) matching entry supplies the data.
module wb_match
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] lk_addr_i,
  input  logic [DEPTH-1:0]  valid_i,
  input  logic [ADDR_W-1:0] addr_i [DEPTH],
  input  byte_lanes_t       data_i [DEPTH],
  output logic              hit_o,
  output byte_lanes_t       data_o
);

  wide_addr_t lk_word;

  assign lk_word = word_addr(wide_addr_t'(lk_addr_i));

  always_comb begin
    // NOTE: defaults assigned first so every path drives the outputs; no latch.
    hit_o  = 1'b0;
    data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_i[i] && (word_addr(wide_addr_t'(addr_i[i])) == lk_word)) begin
        hit_o  = 1'b1;
        data_o = data_i[i];
      end
    end
  end

endmodule

// File: rtl/wb_buffer.sv
// Write-back buffer: in-order FIFO of evicted words drained to memory, with a
// combinational lookup so the core sees its own pending stores.
module wb_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [ADDR_W-1:0] enq_addr,
  input  byte_lanes_t       enq_data,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              lk_hit,
  output byte_lanes_t       lk_data,
  output logic [ADDR_W-1:0] mem_addr,
  output byte_lanes_t       mem_data_in,
  output logic              mem_write_en,
  input  logic              mem_ready,
  input  logic              halted,
  output logic              flushed
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  byte_lanes_t       data_q [DEPTH];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;

  logic enq_fire;
  logic deq_fire;

  logic [ADDR_W-1:0] rot_addr  [DEPTH];
  byte_lanes_t       rot_data  [DEPTH];
  logic [DEPTH-1:0]  rot_valid;

  // Both handshakes depend only on registered state, so a full buffer cannot
  // accept in the same cycle it drains.
  assign enq_ready    = count_q < cnt_t'(DEPTH);
  assign mem_write_en = count_q != '0;
  assign enq_fire     = enq_valid && enq_ready;
  assign deq_fire     = mem_write_en && mem_ready;

  assign mem_addr    = ADDR_W'(word_addr(wide_addr_t'(addr_q[head_q])));
  assign mem_data_in = data_q[head_q];
  assign flushed     = halted && (count_q == '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq_fire) tail_d = tail_q + ptr_t'(1);
    if (deq_fire) head_d = head_q + ptr_t'(1);
    case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_b) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; count_q alone marks validity.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      addr_q[tail_q] <= enq_addr;
      data_q[tail_q] <= enq_data;
    end
  end

  // Present entries oldest-first so the matcher's priority is plain index order.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rot_addr[i]  = addr_q[head_q + ptr_t'(i)];
      rot_data[i]  = data_q[head_q + ptr_t'(i)];
      rot_valid[i] = cnt_t'(i) < count_q;
    end
  end

  wb_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_match (
    .lk_addr_i (lk_addr),
    .valid_i   (rot_valid),
    .addr_i    (rot_addr),
    .data_i    (rot_data),
    .hit_o     (lk_hit),
    .data_o    (lk_data)
  );

endmodule

// File: tb/tb_wb_buffer.sv
// Directed bench for wb_buffer: single write, full/stall, youngest-wins lookup,
// steady enqueue+dequeue with pointer wrap, flush, and reset mid-drain.
module tb_wb_buffer;
  import wb_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst_b;
  logic              enq_valid;
  logic              enq_ready;
  logic [ADDR_W-1:0] enq_addr;
  byte_lanes_t       enq_data;
  logic [ADDR_W-1:0] lk_addr;
  logic              lk_hit;
  byte_lanes_t       lk_data;
  logic [ADDR_W-1:0] mem_addr;
  byte_lanes_t       mem_data_in;
  logic              mem_write_en;
  logic              mem_ready;
  logic              halted;
  logic              flushed;

  int n_checks = 0;
  int n_fail   = 0;

  wb_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .enq_valid    (enq_valid),
    .enq_ready    (enq_ready),
    .enq_addr     (enq_addr),
    .enq_data     (enq_data),
    .lk_addr      (lk_addr),
    .lk_hit       (lk_hit),
    .lk_data      (lk_data),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_ready    (mem_ready),
    .halted       (halted),
    .flushed      (flushed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic byte_lanes_t mk(input logic [7:0] b0, input logic [7:0] b1,
                                     input logic [7:0] b2, input logic [7:0] b3);
    byte_lanes_t r;
    r[0] = b0;
    r[1] = b1;
    r[2] = b2;
    r[3] = b3;
    return r;
  endfunction

  function automatic byte_lanes_t dk(input int k);
    return mk(8'(k), 8'(16 * k), 8'(255 - k), 8'hA5);
  endfunction

  byte_lanes_t d_single, d_a, d_b;

  initial begin
    d_single  = mk(8'h11, 8'h22, 8'h33, 8'h44);
    d_a       = mk(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    d_b       = mk(8'hB0, 8'hB1, 8'hB2, 8'hB3);

    rst_b     = 1'b0;
    enq_valid = 1'b0;
    enq_addr  = '0;
    enq_data  = '0;
    lk_addr   = '0;
    mem_ready = 1'b0;
    halted    = 1'b0;

    // Reset state
    #3;
    check("rst_enq_ready", 64'(enq_ready), 64'd1);
    check("rst_mem_we", 64'(mem_write_en), 64'd0);
    check("rst_lk_hit", 64'(lk_hit), 64'd0);
    check("rst_flushed_lo", 64'(flushed), 64'd0);
    halted = 1'b1;
    #1;
    check("rst_flushed_hi", 64'(flushed), 64'd1);
    halted = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    tick();

    // Single write
    enq_valid = 1'b1;
    enq_addr  = 32'h10;
    enq_data  = d_single;
    mem_ready = 1'b1;
    lk_addr   = 32'h10;
    #1;
    check("single_we_enq_cycle", 64'(mem_write_en), 64'd0);
    check("single_lk_enq_cycle", 64'(lk_hit), 64'd0);
    tick();
    enq_valid = 1'b0;
    #1;
    check("single_we", 64'(mem_write_en), 64'd1);
    check("single_addr", 64'(mem_addr), 64'h10);
    check("single_data", 64'(mem_data_in), 64'(d_single));
    check("single_lk_deq_hit", 64'(lk_hit), 64'd1);
    check("single_lk_deq_data", 64'(lk_data), 64'(d_single));
    tick();
    check("single_we_after", 64'(mem_write_en), 64'd0);
    check("single_empty_ready", 64'(enq_ready), 64'd1);
    check("single_lk_empty", 64'(lk_hit), 64'd0);
    check("single_lk_empty_data", 64'(lk_data), 64'd0);

    // Full and stall
    mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      enq_valid = 1'b1;
      enq_addr  = 32'(4 * k);
      enq_data  = dk(k);
      #1;
      check($sformatf("full_ready_%0d", k), 64'(enq_ready), (k < 4) ? 64'd1 : 64'd0);
      if (k < 4) tick();
    end
    mem_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      check($sformatf("drain_we_%0d", j), 64'(mem_write_en), 64'd1);
      check($sformatf("drain_addr_%0d", j), 64'(mem_addr), 64'(4 * j));
      check($sformatf("drain_data_%0d", j), 64'(mem_data_in), 64'(dk(j)));
      check($sformatf("drain_ready_%0d", j), 64'(enq_ready), (j == 0) ? 64'd0 : 64'd1);
      tick();
      if (j == 1) enq_valid = 1'b0;
    end
    #1;
    check("drain_fifth_addr", 64'(mem_addr), 64'h10);
    check("drain_fifth_data", 64'(mem_data_in), 64'(dk(4)));
    tick();
    check("drain_empty", 64'(mem_write_en), 64'd0);

    // Youngest-wins lookup
    mem_ready = 1'b0;
    enq_valid = 1'b1;
    enq_addr  = 32'h20;
    enq_data  = d_a;
    tick();
    enq_addr  = 32'h23;
    enq_data  = d_b;
    tick();
    enq_valid = 1'b0;
    lk_addr   = 32'h22;
    #1;
    check("yw_hit", 64'(lk_hit), 64'd1);
    check("yw_data", 64'(lk_data), 64'(d_b));
    lk_addr = 32'h24;
    #1;
    check("yw_miss", 64'(lk_hit), 64'd0);
    check("yw_miss_data", 64'(lk_data), 64'd0);
    check("yw_head_addr", 64'(mem_addr), 64'h20);
    check("yw_head_data", 64'(mem_data_in), 64'(d_a));
    mem_ready = 1'b1;
    tick();
    check("yw_second_addr", 64'(mem_addr), 64'h20);
    check("yw_second_data", 64'(mem_data_in), 64'(d_b));
    lk_addr = 32'h20;
    #1;
    check("yw_after_pop_data", 64'(lk_data), 64'(d_b));
    tick();
    check("yw_empty", 64'(mem_write_en), 64'd0);

    // Simultaneous enqueue and dequeue at count 2
    mem_ready = 1'b0;
    enq_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      enq_addr = 32'(32'h100 + 4 * k);
      enq_data = dk(k);
      tick();
    end
    mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      enq_addr = 32'(32'h100 + 4 * (k + 2));
      enq_data = dk(k + 2);
      lk_addr  = 32'(32'h100 + 4 * (k + 2));
      #1;
      check($sformatf("ss_addr_%0d", k), 64'(mem_addr), 64'(32'h100 + 4 * k));
      check($sformatf("ss_data_%0d", k), 64'(mem_data_in), 64'(dk(k)));
      check($sformatf("ss_ready_%0d", k), 64'(enq_ready), 64'd1);
      check($sformatf("ss_new_invisible_%0d", k), 64'(lk_hit), 64'd0);
      lk_addr = 32'(32'h100 + 4 * (k + 1));
      #1;
      check($sformatf("ss_lk_hit_%0d", k), 64'(lk_hit), 64'd1);
      check($sformatf("ss_lk_data_%0d", k), 64'(lk_data), 64'(dk(k + 1)));
      tick();
    end
    enq_valid = 1'b0;
    for (int k = 10; k < 12; k++) begin
      #1;
      check($sformatf("ss_tail_we_%0d", k), 64'(mem_write_en), 64'd1);
      check($sformatf("ss_tail_addr_%0d", k), 64'(mem_addr), 64'(32'h100 + 4 * k));
      check($sformatf("ss_tail_data_%0d", k), 64'(mem_data_in), 64'(dk(k)));
      tick();
    end
    check("ss_empty", 64'(mem_write_en), 64'd0);

    // Flush
    mem_ready = 1'b0;
    enq_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      enq_addr = 32'(32'h200 + 4 * k);
      enq_data = dk(20 + k);
      tick();
    end
    enq_valid = 1'b0;
    halted    = 1'b1;
    #1;
    check("flush_pending", 64'(flushed), 64'd0);
    check("flush_halt_ready", 64'(enq_ready), 64'd1);
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("flush_addr_%0d", k), 64'(mem_addr), 64'(32'h200 + 4 * k));
      check($sformatf("flush_not_yet_%0d", k), 64'(flushed), 64'd0);
      tick();
    end
    check("flush_done", 64'(flushed), 64'd1);
    check("flush_we", 64'(mem_write_en), 64'd0);
    halted = 1'b0;
    #1;
    check("flush_unhalt", 64'(flushed), 64'd0);

    // Reset mid-drain
    mem_ready = 1'b0;
    enq_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      enq_addr = 32'(32'h300 + 4 * k);
      enq_data = dk(40 + k);
      tick();
    end
    enq_valid = 1'b0;
    #1;
    check("rmd_we_before", 64'(mem_write_en), 64'd1);
    #1;
    rst_b = 1'b0;
    #1;
    check("rmd_we_async", 64'(mem_write_en), 64'd0);
    check("rmd_ready_in_reset", 64'(enq_ready), 64'd1);
    @(negedge clk);
    rst_b = 1'b1;
    tick();
    check("rmd_ready", 64'(enq_ready), 64'd1);
    check("rmd_we_after", 64'(mem_write_en), 64'd0);
    lk_addr = 32'h300;
    #1;
    check("rmd_lk_300", 64'(lk_hit), 64'd0);
    lk_addr = 32'h308;
    #1;
    check("rmd_lk_308", 64'(lk_hit), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
